// File: rtl/countdown_timer.sv
// countdown_timer: HH:MM:SS countdown held as six 7-bit digit codes.
// Loads are validated against the digit code table and time ranges.
// Counting is enabled by start and paused by stop; each tick subtracts
// one second with a borrow chain across the digits. Reaching 00:00:00
// enters DONE and pulses done for one cycle.
module countdown_timer (
    input  logic        timer_clk,
    input  logic        int_reset_b,
    input  logic        tick,
    input  logic        load,
    input  logic [41:0] load_digits,
    input  logic        start,
    input  logic        stop,
    output logic [41:0] digits_out,
    output logic        running,
    output logic        done,
    output logic        load_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1011100;
    localparam logic [6:0] SEG_5 = 7'b0110100;
    localparam logic [6:0] SEG_6 = 7'b0110000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0010000;
    localparam logic [6:0] SEG_9 = 7'b0010100;

    localparam logic [3:0]  VAL_ILLEGAL = 4'hF;
    localparam logic [41:0] ZERO_COUNT  = {6{SEG_0}};

    // Code to numeric value; VAL_ILLEGAL for anything outside the table.
    function automatic logic [3:0] seg_to_val(input logic [6:0] seg);
        logic [3:0] v;
        case (seg)
            SEG_0:   v = 4'd0;
            SEG_1:   v = 4'd1;
            SEG_2:   v = 4'd2;
            SEG_3:   v = 4'd3;
            SEG_4:   v = 4'd4;
            SEG_5:   v = 4'd5;
            SEG_6:   v = 4'd6;
            SEG_7:   v = 4'd7;
            SEG_8:   v = 4'd8;
            SEG_9:   v = 4'd9;
            default: v = VAL_ILLEGAL;
        endcase
        return v;
    endfunction

    function automatic logic [6:0] val_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_0;
        endcase
        return seg;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [41:0] digits_q, digits_d;
    logic        done_q, done_d;
    logic        load_err_q, load_err_d;

    logic [3:0]  ht_v, ho_v, mt_v, mo_v, st_v, so_v;
    logic [6:0]  hr_val;
    logic        load_ok;

    logic [41:0] dec_digits;
    logic [3:0]  dig_v;
    logic        borrow;

    assign ht_v = seg_to_val(load_digits[41:35]);
    assign ho_v = seg_to_val(load_digits[34:28]);
    assign mt_v = seg_to_val(load_digits[27:21]);
    assign mo_v = seg_to_val(load_digits[20:14]);
    assign st_v = seg_to_val(load_digits[13:7]);
    assign so_v = seg_to_val(load_digits[6:0]);

    assign hr_val = 7'(ht_v) * 7'd10 + 7'(ho_v);

    // Load image must use legal codes with tens-of-minutes/seconds <= 5 and hours <= 23.
    always_comb begin
        load_ok = (ht_v != VAL_ILLEGAL) && (ho_v != VAL_ILLEGAL) &&
                  (mt_v != VAL_ILLEGAL) && (mo_v != VAL_ILLEGAL) &&
                  (st_v != VAL_ILLEGAL) && (so_v != VAL_ILLEGAL) &&
                  (mt_v <= 4'd5) && (st_v <= 4'd5) && (hr_val <= 7'd23);
    end

    // One-second decrement: ripple a borrow from sec_ones up to hr_tens.
    always_comb begin
        dec_digits = digits_q;
        borrow     = 1'b1;
        dig_v      = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (borrow) begin
                dig_v = seg_to_val(digits_q[7*i +: 7]);
                if (dig_v == VAL_ILLEGAL) begin
                    // Corrupted digit recovers to zero and absorbs the borrow.
                    dec_digits[7*i +: 7] = SEG_0;
                    borrow               = 1'b0;
                end else if (dig_v != 4'd0) begin
                    dec_digits[7*i +: 7] = val_to_seg(dig_v - 4'd1);
                    borrow               = 1'b0;
                end else if (i == 5) begin
                    borrow = 1'b0;
                end else if ((i == 1) || (i == 3)) begin
                    dec_digits[7*i +: 7] = SEG_5;
                end else begin
                    dec_digits[7*i +: 7] = SEG_9;
                end
            end
        end
    end

    // Control: load (outside RUN) beats stop, stop beats tick/start.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (load && (state_q != ST_RUN)) begin
            if (load_ok) begin
                digits_d = load_digits;
                state_d  = ST_IDLE;
            end else begin
                // Back-to-back rejected loads still give a single-cycle pulse.
                load_err_d = ~load_err_q;
            end
        end else if (state_q == ST_RUN) begin
            if (stop) begin
                state_d = ST_PAUSE;
            end else if (tick) begin
                digits_d = dec_digits;
                if (dec_digits == ZERO_COUNT) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) &&
                     (digits_q != ZERO_COUNT)) begin
            state_d = ST_RUN;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge timer_clk or negedge int_reset_b) begin
        if (!int_reset_b) begin
            state_q    <= ST_IDLE;
            digits_q   <= ZERO_COUNT;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign digits_out = digits_q;
    assign running    = (state_q == ST_RUN);
    assign done       = done_q;
    assign load_err   = load_err_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have no parameters; the digit encoding is fixed: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1011100, 5=0110100, 6=0110000, 7=0001111, 8=0010000, 9=0010100.
REQ-002 timer_clk  input  1  single clock; all state changes on rising edge.
REQ-003 int_reset_b  input  1  asynchronous, active-low reset.
REQ-004 tick  input  1  one-cycle count-enable pulse, one per counted second.
REQ-005 load  input  1  one-cycle request to load load_digits.
REQ-006 load_digits  input  42  {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}, 7 bits each, in the REQ-001 encoding.
REQ-007 start  input  1  begin or resume counting.
REQ-008 stop  input  1  pause counting.
REQ-009 digits_out  output  42  current count, same packing and encoding as load_digits, registered.
REQ-010 running  output  1  high while state is RUN.
REQ-011 done  output  1  one-cycle pulse when the count reaches 00:00:00.
REQ-012 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, DONE; running = (state == RUN).
REQ-014 load in IDLE, PAUSE or DONE SHALL validate load_digits: every field a legal code, sec_tens <= 5, min_tens <= 5, hour value <= 23.
REQ-015 A valid load SHALL update digits_out on the next edge and move the state to IDLE.
REQ-016 An invalid load SHALL leave digits_out and state unchanged and pulse load_err on the next edge.
REQ-017 load in RUN SHALL be ignored, with no load_err.
REQ-018 start in IDLE or PAUSE with a non-zero count SHALL enter RUN on the next edge.
REQ-019 start with a count of 00:00:00, or start in DONE, SHALL be ignored.
REQ-020 stop in RUN SHALL enter PAUSE; in any other state it SHALL be ignored.
REQ-021 Priority when asserted in the same cycle: load > stop > start.
REQ-022 tick in RUN SHALL decrement the count by one second; digits_out SHALL change on the edge that samples tick (latency 1).
REQ-023 tick outside RUN SHALL be ignored; tick in the same cycle as stop SHALL be ignored (stop wins).
REQ-024 Decrement rules, applied in order sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens:
  - a digit decrements if it is non-zero;
  - a zero digit wraps (sec_ones/min_ones/hr_ones to 9, sec_tens/min_tens to 5) and borrows from the next digit;
  - hr_tens never wraps, because 00:00:00 is never decremented.
REQ-025 The tick that produces 00:00:00 SHALL enter DONE on the same edge and pulse done on that edge for exactly one cycle.
REQ-026 DONE SHALL hold 00:00:00 until a valid load.
REQ-027 A digit holding an illegal code (not reachable except via fault) SHALL decrement to 0 code without borrowing.
REQ-028 done and load_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-029 While int_reset_b is low, SHALL asynchronously force: digits_out = six 0 codes (00:00:00), state IDLE, running=0, done=0, load_err=0.
REQ-030 Reset asserted mid-RUN SHALL take effect immediately, with no done pulse.
REQ-031 After release, SHALL require a valid load before start has effect.

Verification
REQ-032 Load 00:01:00, start, 1 tick -> digits_out 00:00:59 one cycle after the tick; running=1.
REQ-033 Load 10:00:00, run, 1 tick -> 09:59:59 (full borrow chain).
REQ-034 Load 00:00:02, run, 2 ticks -> 00:00:00, done high exactly one cycle, state DONE, further ticks ignored.
REQ-035 Load with hour 24, or sec_tens=6, or a bad code -> load_err one cycle, digits_out unchanged.
REQ-036 In RUN, stop+tick in the same cycle -> PAUSE, count unchanged; start -> RUN resumes; load during RUN ignored.
REQ-037 Assert int_reset_b low mid-count -> immediate 00:00:00, IDLE, no done; start after release has no effect.
